// File: rtl/mesi_bus_ctrl.sv
// rtl/mesi_bus_ctrl.sv - snooping-bus responder for per-line MESI caches.
// One transaction at a time: round-robin grant, one-cycle snoop, response collect, optional memory access.
module mesi_bus_ctrl #(
  parameter int NUM_CACHES = 4,
  parameter int ADDR_W     = 32,
  parameter int ID_W       = $clog2(NUM_CACHES)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CACHES-1:0]          req_valid,
  input  logic [2*NUM_CACHES-1:0]        req_op,
  input  logic [ADDR_W*NUM_CACHES-1:0]   req_addr,
  output logic [NUM_CACHES-1:0]          req_done,
  output logic                           resp_shared,
  output logic                           snoop_valid,
  output logic [1:0]                     snoop_op,
  output logic [ADDR_W-1:0]              snoop_addr,
  output logic [ID_W-1:0]                snoop_src,
  input  logic [NUM_CACHES-1:0]          snoop_shared_in,
  input  logic [NUM_CACHES-1:0]          snoop_flush_in,
  output logic                           mem_req,
  output logic                           mem_we,
  output logic [ADDR_W-1:0]              mem_addr,
  input  logic                           mem_ack,
  output logic                           busy,
  output logic                           proto_err
);

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_RDX  = 2'b10;
  localparam logic [1:0] OP_UPGR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SNOOP,
    S_RESP,
    S_MEM_WB,
    S_MEM_RD,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                shared_q, shared_d;
  logic                proto_err_q, proto_err_d;

  logic [NUM_CACHES-1:0] eligible;
  logic                  grant_found;
  logic [ID_W-1:0]       grant_id;
  logic [NUM_CACHES-1:0] src_onehot;
  logic [NUM_CACHES-1:0] shared_masked;
  logic [NUM_CACHES-1:0] flush_masked;
  logic                  sh;
  logic                  fl;
  logic                  multi_flush;

  always_comb begin
    for (int i = 0; i < NUM_CACHES; i++) begin
      eligible[i] = req_valid[i] && (req_op[2*i +: 2] != OP_NONE);
    end
  end

  // First eligible requester at or after rr_ptr, wrapping around.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int k = 0; k < NUM_CACHES; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_CACHES) begin
        idx = idx - NUM_CACHES;
      end
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  // The requester never answers its own snoop, whatever it drives.
  assign src_onehot    = {{(NUM_CACHES-1){1'b0}}, 1'b1} << id_q;
  assign shared_masked = snoop_shared_in & ~src_onehot;
  assign flush_masked  = snoop_flush_in & ~src_onehot;
  assign sh            = |shared_masked;
  assign fl            = |flush_masked;
  assign multi_flush   = |(flush_masked & (flush_masked - NUM_CACHES'(1)));

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    id_d        = id_q;
    rr_ptr_d    = rr_ptr_q;
    shared_d    = shared_q;
    proto_err_d = proto_err_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          state_d = S_SNOOP;
          id_d    = grant_id;
          op_d    = req_op[2*int'(grant_id) +: 2];
          addr_d  = req_addr[int'(grant_id)*ADDR_W +: ADDR_W];
        end
      end
      S_SNOOP: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        shared_d = (op_q == OP_RD) && (sh || fl);
        if (multi_flush || (fl && (op_q == OP_UPGR))) begin
          proto_err_d = 1'b1;
        end
        // A flushed line reaches the requester cache-to-cache; memory only takes the writeback.
        if (fl) begin
          state_d = S_MEM_WB;
        end else if ((op_q == OP_RD) || (op_q == OP_RDX)) begin
          state_d = S_MEM_RD;
        end else begin
          state_d = S_DONE;
        end
      end
      S_MEM_WB, S_MEM_RD: begin
        if (mem_ack) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        rr_ptr_d = (id_q == ID_W'(NUM_CACHES-1)) ? '0 : id_q + ID_W'(1);
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    req_done    = '0;
    resp_shared = 1'b0;
    snoop_valid = 1'b0;
    snoop_op    = '0;
    snoop_addr  = '0;
    snoop_src   = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    busy        = (state_q != S_IDLE);
    proto_err   = proto_err_q;
    case (state_q)
      S_SNOOP: begin
        snoop_valid = 1'b1;
        snoop_op    = op_q;
        snoop_addr  = addr_q;
        snoop_src   = id_q;
      end
      S_MEM_WB: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = addr_q;
      end
      S_MEM_RD: begin
        mem_req  = 1'b1;
        mem_addr = addr_q;
      end
      S_DONE: begin
        req_done    = src_onehot;
        resp_shared = shared_q;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_NONE;
      addr_q      <= '0;
      id_q        <= '0;
      rr_ptr_q    <= '0;
      shared_q    <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      id_q        <= id_d;
      rr_ptr_q    <= rr_ptr_d;
      shared_q    <= shared_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_mesi_bus_ctrl.sv
// tb/tb_mesi_bus_ctrl.sv - self-checking bench for mesi_bus_ctrl.
// Completions are checked against a scoreboard queue filled when each request is driven.
module tb_mesi_bus_ctrl;
  localparam int N  = 4;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [2*N-1:0]  req_op;
  logic [AW*N-1:0] req_addr;
  logic [N-1:0]    req_done;
  logic            resp_shared;
  logic            snoop_valid;
  logic [1:0]      snoop_op;
  logic [AW-1:0]   snoop_addr;
  logic [1:0]      snoop_src;
  logic [N-1:0]    snoop_shared_in;
  logic [N-1:0]    snoop_flush_in;
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic            mem_ack;
  logic            busy;
  logic            proto_err;

  typedef struct {
    int   id;
    logic sh;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   dones_seen = 0;

  always #5 clk = ~clk;

  mesi_bus_ctrl #(.NUM_CACHES(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
    .req_done(req_done), .resp_shared(resp_shared),
    .snoop_valid(snoop_valid), .snoop_op(snoop_op), .snoop_addr(snoop_addr), .snoop_src(snoop_src),
    .snoop_shared_in(snoop_shared_in), .snoop_flush_in(snoop_flush_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .busy(busy), .proto_err(proto_err)
  );

  // Scoreboard: every completion pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (req_done !== 4'b0000) begin
      dones_seen++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected_done: req_done=%b resp_shared=%b, required no completion", req_done, resp_shared);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (req_done !== (4'b0001 << e.id)) begin
          errors++;
          $display("FAIL sb_done_id: req_done=%b, required id %0d", req_done, e.id);
        end
        checks++;
        if (resp_shared !== e.sh) begin
          errors++;
          $display("FAIL sb_resp_shared: resp_shared=%b, required %b (id %0d)", resp_shared, e.sh, e.id);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic [1:0] op, input logic [31:0] a);
    req_valid[i]         = v;
    req_op[2*i +: 2]     = op;
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0; req_op = '0; req_addr = '0;
    snoop_shared_in = '0; snoop_flush_in = '0; mem_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({req_done, resp_shared, snoop_valid, snoop_op, snoop_addr, snoop_src} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req_done=%b snoop_valid=%b snoop_addr=%h, required all 0", req_done, snoop_valid, snoop_addr);
    end
    checks++;
    if ({mem_req, mem_we, mem_addr, busy, proto_err} !== '0) begin
      errors++;
      $display("FAIL reset_mem_status: mem_req=%b busy=%b proto_err=%b, required 0", mem_req, busy, proto_err);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL stray_mem_ack: busy=%b mem_req=%b, required 0 0", busy, mem_req);
    end
  endtask

  task automatic test_busrd_no_resp();
    logic [31:0] a;
    a = 32'h0000_1a40;
    exp_q.push_back('{2, 1'b0});
    set_req(2, 1'b1, 2'b01, a);
    tick();
    checks++;
    if (snoop_valid !== 1'b1 || snoop_src !== 2'd2 || snoop_op !== 2'b01 || snoop_addr !== a) begin
      errors++;
      $display("FAIL rd_snoop: valid=%b src=%0d op=%b addr=%h, required 1 2 01 %h", snoop_valid, snoop_src, snoop_op, snoop_addr, a);
    end
    snoop_flush_in = 4'b1111;
    tick();
    snoop_flush_in = '0;
    checks++;
    if (snoop_valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL rd_resp_cycle: snoop_valid=%b mem_req=%b, required 0 0", snoop_valid, mem_req);
    end
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== a) begin
      errors++;
      $display("FAIL rd_mem_start: mem_req=%b mem_we=%b mem_addr=%h, required 1 0 %h", mem_req, mem_we, mem_addr, a);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== a || req_done !== 4'b0000) begin
        errors++;
        $display("FAIL rd_mem_hold: mem_req=%b mem_addr=%h req_done=%b, required 1 %h 0000", mem_req, mem_addr, req_done, a);
      end
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++;
    if (req_done !== 4'b0100 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL rd_done: req_done=%b mem_req=%b, required 0100 0", req_done, mem_req);
    end
    set_req(2, 1'b0, 2'b00, 32'h0);
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rd_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_busrd_shared_flush();
    for (int pass = 0; pass < 2; pass++) begin
      logic [31:0] a;
      a = (pass == 0) ? 32'h0000_2000 : 32'h0000_3040;
      exp_q.push_back('{0, 1'b1});
      set_req(0, 1'b1, 2'b01, a);
      tick();
      checks++;
      if (snoop_src !== 2'd0) begin
        errors++;
        $display("FAIL shfl_snoop_src: snoop_src=%0d, required 0 (pass %0d)", snoop_src, pass);
      end
      tick();
      if (pass == 0) snoop_shared_in = 4'b0010;
      else snoop_flush_in = 4'b0010;
      tick();
      snoop_shared_in = '0; snoop_flush_in = '0;
      checks++;
      if (mem_req !== 1'b1 || mem_we !== logic'(pass) || mem_addr !== a) begin
        errors++;
        $display("FAIL shfl_mem: mem_req=%b mem_we=%b mem_addr=%h, required 1 %0d %h", mem_req, mem_we, mem_addr, pass, a);
      end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checks++;
      if (req_done !== 4'b0001 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL shfl_done: req_done=%b mem_req=%b, required 0001 0 (pass %0d)", req_done, mem_req, pass);
      end
      set_req(0, 1'b0, 2'b00, 32'h0);
      tick();
    end
  endtask

  task automatic test_upgr_own_shared();
    exp_q.push_back('{3, 1'b0});
    set_req(3, 1'b1, 2'b11, 32'h0000_4480);
    tick();
    checks++;
    if (snoop_valid !== 1'b1 || snoop_src !== 2'd3 || snoop_op !== 2'b11) begin
      errors++;
      $display("FAIL upgr_snoop: valid=%b src=%0d op=%b, required 1 3 11", snoop_valid, snoop_src, snoop_op);
    end
    set_req(1, 1'b1, 2'b01, 32'h0000_5000);
    tick();
    snoop_shared_in = 4'b1000;
    snoop_flush_in  = 4'b1000;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL upgr_resp_mem: mem_req=%b, required 0", mem_req);
    end
    tick();
    snoop_shared_in = '0; snoop_flush_in = '0;
    checks++;
    if (req_done !== 4'b1000 || mem_req !== 1'b0 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL upgr_done: req_done=%b mem_req=%b proto_err=%b, required 1000 0 0", req_done, mem_req, proto_err);
    end
    set_req(3, 1'b0, 2'b00, 32'h0);
    set_req(1, 1'b0, 2'b00, 32'h0);
    tick(); tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL dropped_req_served: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      set_req(i, 1'b1, 2'b10, 32'h0000_0040 + 32'(i) * 32'h100);
      exp_q.push_back('{i, 1'b0});
    end
    for (int k = 0; k < N; k++) begin
      tick();
      checks++;
      if (snoop_valid !== 1'b1 || snoop_src !== 2'(k) || snoop_addr !== 32'h0000_0040 + 32'(k) * 32'h100) begin
        errors++;
        $display("FAIL rr_grant: valid=%b src=%0d addr=%h, required 1 %0d", snoop_valid, snoop_src, snoop_addr, k);
      end
      tick();
      snoop_shared_in = 4'b1111;
      tick();
      snoop_shared_in = '0;
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0) begin
        errors++;
        $display("FAIL rr_mem: mem_req=%b mem_we=%b, required 1 0 (grant %0d)", mem_req, mem_we, k);
      end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      set_req(k, 1'b0, 2'b00, 32'h0);
      tick();
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL rr_idle_gap: busy=%b, required 0 (after grant %0d)", busy, k);
      end
    end
    set_req(1, 1'b1, 2'b11, 32'h0000_6000);
    set_req(3, 1'b1, 2'b11, 32'h0000_7000);
    exp_q.push_back('{1, 1'b0});
    exp_q.push_back('{3, 1'b0});
    tick();
    checks++;
    if (snoop_src !== 2'd1) begin
      errors++;
      $display("FAIL rr_wrap: snoop_src=%0d, required 1", snoop_src);
    end
    tick(); tick();
    checks++;
    if (req_done !== 4'b0010) begin
      errors++;
      $display("FAIL non_granted_done: req_done=%b, required 0010", req_done);
    end
    set_req(1, 1'b0, 2'b00, 32'h0);
    tick(); tick();
    checks++;
    if (snoop_src !== 2'd3 || snoop_valid !== 1'b1) begin
      errors++;
      $display("FAIL rr_second: snoop_src=%0d valid=%b, required 3 1", snoop_src, snoop_valid);
    end
    tick(); tick();
    set_req(3, 1'b0, 2'b00, 32'h0);
    tick();
  endtask

  task automatic test_multi_flush_and_reset();
    exp_q.push_back('{0, 1'b1});
    set_req(0, 1'b1, 2'b01, 32'h0000_8880);
    tick(); tick();
    snoop_flush_in = 4'b0110;
    tick();
    snoop_flush_in = '0;
    checks++;
    if (proto_err !== 1'b1 || mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h0000_8880) begin
      errors++;
      $display("FAIL multi_flush_wb: proto_err=%b mem_req=%b mem_we=%b mem_addr=%h, required 1 1 1 00008880", proto_err, mem_req, mem_we, mem_addr);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    set_req(0, 1'b0, 2'b00, 32'h0);
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL multi_flush_single_wb: mem_req=%b, required 0", mem_req);
    end
    tick();
    checks++;
    if (proto_err !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL proto_err_sticky: proto_err=%b mem_req=%b, required 1 0", proto_err, mem_req);
    end
    set_req(2, 1'b1, 2'b01, 32'h0000_9900);
    tick(); tick(); tick();
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL rst_pre_mem: mem_req=%b mem_we=%b, required 1 0", mem_req, mem_we);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(2, 1'b0, 2'b00, 32'h0);
    checks++;
    if ({req_done, resp_shared, snoop_valid, mem_req, mem_we, mem_addr, busy, proto_err} !== '0) begin
      errors++;
      $display("FAIL mid_txn_reset: req_done=%b mem_req=%b busy=%b proto_err=%b, required all 0", req_done, mem_req, busy, proto_err);
    end
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b, required 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_busrd_no_resp();
    test_busrd_shared_flush();
    test_upgr_own_shared();
    test_back_to_back();
    test_multi_flush_and_reset();
    checks++;
    if (exp_q.size() != 0 || dones_seen != 11) begin
      errors++;
      $display("FAIL completion_count: outstanding=%0d seen=%0d, required 0 11", exp_q.size(), dones_seen);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
